// File: rtl/tsu_pkg.sv
// tsu_pkg: shared defaults and helpers for the multi-channel timestamp queue.
//   STAT_W_DEF / DATA_W_DEF : default record field widths
//   DROP_CNT_W              : width of the dropped-record counter
//   clog2 / ch_w / rec_w    : width helpers (channel-ID width is never below 1)
// Record layout in FIFO memory, MSB to LSB: {ch, stat, data}.
package tsu_pkg;

  localparam int STAT_W_DEF = 8;
  localparam int DATA_W_DEF = 48;
  localparam int DROP_CNT_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel ID width: a single channel still gets a 1-bit (constant 0) ID.
  function automatic int ch_w(input int ch_num);
    return (ch_num <= 1) ? 1 : clog2(ch_num);
  endfunction

  // Field offsets inside a packed record: data at 0, stat above it, ch on top.
  function automatic int rec_stat_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rec_ch_lsb(input int stat_w, input int data_w);
    return stat_w + data_w;
  endfunction

  function automatic int rec_w(input int chw, input int stat_w, input int data_w);
    return rec_ch_lsb(stat_w, data_w) + chw;
  endfunction

endpackage

// File: rtl/tsu_rr_arb.sv
// tsu_rr_arb: round-robin arbiter over CH_NUM requesters.
//   q_clk, rst : clock, async active-high reset
//   req        : per-channel eligible request
//   en         : grant allowed this cycle
//   gnt        : one-hot grant (zero when nothing granted)
//   gnt_id     : encoded ID of the first requester at/after the RR pointer
//   gnt_vld    : a grant was issued this cycle
// The RR pointer moves to (granted ID + 1) mod CH_NUM only when a grant is issued.
module tsu_rr_arb
  import tsu_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int CH_W   = ch_w(CH_NUM)
) (
  input  logic              q_clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] req,
  input  logic              en,
  output logic [CH_NUM-1:0] gnt,
  output logic [CH_W-1:0]   gnt_id,
  output logic              gnt_vld
);

  logic [CH_W-1:0] rr_ptr;

  // Pick the requester with the smallest circular distance from the pointer.
  always_comb begin : p_pick
    int best_d;
    int d;
    best_d = CH_NUM;
    d      = 0;
    gnt_id = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      d = (c >= int'(rr_ptr)) ? c - int'(rr_ptr) : c + CH_NUM - int'(rr_ptr);
      if (req[c] && d < best_d) begin
        best_d = d;
        gnt_id = CH_W'(c);
      end
    end
    gnt_vld = en && (best_d < CH_NUM);
    gnt     = gnt_vld ? (CH_NUM'(1) << gnt_id) : '0;
  end

  always_ff @(posedge q_clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (gnt_vld)
      rr_ptr <= (gnt_id == CH_W'(CH_NUM - 1)) ? '0 : gnt_id + CH_W'(1);
  end

endmodule

// File: rtl/tsu_mq_queue.sv
// tsu_mq_queue: multi-channel timestamp queue. CH_NUM producers hand {stat,data}
// records over a req/ack handshake; a round-robin arbiter writes at most one
// record per cycle, tagged with its channel ID, into a shared show-ahead FIFO.
//   q_clk, rst          : clock, async active-high reset
//   ts_req/stat/data    : per-channel level request and record (flattened per channel)
//   ts_ack              : one-cycle accept pulse, the cycle after the grant
//   q_rd_en             : pop head entry (ignored when empty)
//   q_rd_ch/stat/data   : head entry, zero while empty
//   q_empty, q_rd_cnt   : FIFO status, count 0..2**ADDR_W
//   q_drop_cnt          : saturating count of discarded records
// Build option TSU_QUEUE_DROP_EN: when defined, records arriving while the FIFO is
// full are still acked but discarded and counted; otherwise the FIFO back-pressures
// (no grant while full) and q_drop_cnt is tied to zero.
module tsu_mq_queue
  import tsu_pkg::*;
#(
  parameter int CH_NUM = 2,
  parameter int STAT_W = STAT_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 4,
  parameter int CH_W   = ch_w(CH_NUM)
) (
  input  logic                     q_clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        ts_req,
  input  logic [CH_NUM*STAT_W-1:0] ts_stat,
  input  logic [CH_NUM*DATA_W-1:0] ts_data,
  output logic [CH_NUM-1:0]        ts_ack,
  input  logic                     q_rd_en,
  output logic [CH_W-1:0]          q_rd_ch,
  output logic [STAT_W-1:0]        q_rd_stat,
  output logic [DATA_W-1:0]        q_rd_data,
  output logic                     q_empty,
  output logic [ADDR_W:0]          q_rd_cnt,
  output logic [DROP_CNT_W-1:0]    q_drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int REC_W = rec_w(CH_W, STAT_W, DATA_W);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [STAT_W-1:0] stat;
    logic [DATA_W-1:0] data;
  } rec_t;

  logic [CH_NUM-1:0][STAT_W-1:0] stat_a;
  logic [CH_NUM-1:0][DATA_W-1:0] data_a;
  assign stat_a = ts_stat;
  assign data_a = ts_data;

  rec_t             mem [DEPTH];
  rec_t             wr_rec, head;
  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic             full, pop, wr_ok, push, arb_en;
  logic [CH_NUM-1:0] elig, gnt;
  logic [CH_W-1:0]  gnt_id;
  logic             gnt_vld;

  assign q_empty  = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign q_rd_cnt = wr_ptr - rd_ptr;
  assign pop      = q_rd_en && !q_empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign wr_ok    = !full || pop;
  // A request is ignored while its own ack is high (producer has not dropped it yet).
  assign elig     = ts_req & ~ts_ack;

`ifdef TSU_QUEUE_DROP_EN
  assign arb_en = 1'b1;
`else
  assign arb_en = wr_ok;
`endif

  tsu_rr_arb #(.CH_NUM(CH_NUM), .CH_W(CH_W)) u_arb (
    .q_clk   (q_clk),
    .rst     (rst),
    .req     (elig),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign push        = gnt_vld && wr_ok;
  assign wr_rec.ch   = gnt_id;
  assign wr_rec.stat = stat_a[gnt_id];
  assign wr_rec.data = data_a[gnt_id];

  // Memory carries no reset; the read port is masked while empty instead.
  always_ff @(posedge q_clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wr_rec;
  end

  assign head = mem[rd_ptr[ADDR_W-1:0]];
  assign {q_rd_ch, q_rd_stat, q_rd_data} = q_empty ? REC_W'(0) : head;

  always_ff @(posedge q_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ts_ack <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      ts_ack <= gnt;
    end
  end

`ifdef TSU_QUEUE_DROP_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
  always_ff @(posedge q_clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (gnt_vld && !wr_ok && drop_cnt != '1)
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  end
  assign q_drop_cnt = drop_cnt;
`else
  assign q_drop_cnt = '0;
`endif

endmodule
